// File: rtl/node_memory_bank.sv
// Byte-addressed node state bank with big-endian word access, a registered read port,
// per-byte write enables, range checking and a hardware clear sweep.
module node_memory_bank #(
  parameter int BYTE_W     = 8,
  parameter int WORD_BYTES = 2,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 16
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            index,
  input  logic [WORD_BYTES-1:0]        byte_en,
  input  logic [WORD_BYTES*BYTE_W-1:0] data_in,
  input  logic                         clr_req,
  output logic [WORD_BYTES*BYTE_W-1:0] data_out,
  output logic                         rd_valid,
  output logic                         addr_err,
  output logic                         busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW    = WORD_BYTES * BYTE_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [WW-1:0]    dout_q, dout_d;
  logic             rv_q, ae_q;
  logic [BYTE_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0] end_addr;
  logic            legal, idle, acc_rd, acc_wr, acc_bad;

  // Range check carries one extra bit so index near the top of the port cannot wrap.
  assign end_addr = {1'b0, index} + (ADDR_W+1)'(WORD_BYTES);
  assign legal    = end_addr <= (ADDR_W+1)'(DEPTH);
  assign idle     = (state_q == ST_IDLE);
  assign acc_rd   = idle & rd_en & legal;
  assign acc_wr   = idle & wr_en & legal;
  assign acc_bad  = idle & (rd_en | wr_en) & ~legal;

  // Lane k is the byte at index+k; lane 0 is the word MSB.
  logic [WORD_BYTES-1:0][PTR_W-1:0]  lane_addr;
  logic [WORD_BYTES-1:0]             lane_we;
  logic [WORD_BYTES-1:0][BYTE_W-1:0] lane_wdata;
  logic [WW-1:0]                     rd_word;

  for (genvar k = 0; k < WORD_BYTES; k++) begin : g_lane
    localparam int S = WORD_BYTES - 1 - k;
    assign lane_addr[k]                 = PTR_W'(index + ADDR_W'(k));
    assign lane_we[k]                   = acc_wr & byte_en[S];
    assign lane_wdata[k]                = data_in[S*BYTE_W +: BYTE_W];
    assign rd_word[S*BYTE_W +: BYTE_W]  = mem_q[lane_addr[k]];
  end

  // Array is never reset; the sweep is the only way it gets zeroed.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[ptr_q] <= '0;
    end else begin
      for (int k = 0; k < WORD_BYTES; k++)
        if (lane_we[k]) mem_q[lane_addr[k]] <= lane_wdata[k];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == PTR_W'(DEPTH - 1)) begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    end else if (clr_req) begin
      state_d = ST_CLEAR;
      ptr_d   = '0;
    end
  end

  // Read data is sampled from the array before this edge's write lands.
  assign dout_d = acc_rd ? rd_word : dout_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      dout_q  <= '0;
      rv_q    <= 1'b0;
      ae_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      rv_q    <= acc_rd;
      ae_q    <= acc_bad;
    end
  end

  assign data_out = dout_q;
  assign rd_valid = rv_q;
  assign addr_err = ae_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_node_memory_bank.sv
// Bench for node_memory_bank: byte-array reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_node_memory_bank;
  localparam int BW = 8, WB = 2, DEPTH = 64, AW = 16, DW = WB*BW;

  logic          clk = 1'b0, nrst = 1'b0;
  logic          wr_en = 1'b0, rd_en = 1'b0, clr_req = 1'b0;
  logic [AW-1:0] index = '0;
  logic [WB-1:0] byte_en = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          rd_valid, addr_err, busy;

  node_memory_bank #(.BYTE_W(BW), .WORD_BYTES(WB), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .nrst(nrst), .wr_en(wr_en), .rd_en(rd_en), .index(index),
    .byte_en(byte_en), .data_in(data_in), .clr_req(clr_req),
    .data_out(data_out), .rd_valid(rd_valid), .addr_err(addr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain byte array plus a count of sweep cycles still to run.
  logic [BW-1:0] mem_m [DEPTH];
  int            sweep_left;
  logic [DW-1:0] exp_dout;
  bit            exp_rv, exp_ae, ok;
  int            mi;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sweep_left = DEPTH;
      exp_dout = '0; exp_rv = 0; exp_ae = 0;
    end else if (sweep_left > 0) begin
      mem_m[DEPTH - sweep_left] = '0;
      sweep_left--;
      exp_rv = 0; exp_ae = 0;
    end else begin
      mi = int'(index);
      ok = (mi + WB) <= DEPTH;
      exp_rv = rd_en && ok;
      exp_ae = (rd_en || wr_en) && !ok;
      if (exp_rv)
        for (int k = 0; k < WB; k++) exp_dout[(WB-1-k)*BW +: BW] = mem_m[mi+k];
      if (wr_en && ok)
        for (int k = 0; k < WB; k++)
          if (byte_en[WB-1-k]) mem_m[mi+k] = data_in[(WB-1-k)*BW +: BW];
      if (clr_req) sweep_left = DEPTH;
    end
  end

  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", {31'd0, busy}, {31'd0, sweep_left > 0});
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, exp_rv});
      chk("addr_err", {31'd0, addr_err}, {31'd0, exp_ae});
      chk("data_out", {16'd0, data_out}, {16'd0, exp_dout});
      chk("rv_ae_excl", {31'd0, rd_valid & addr_err}, 32'd0);
    end
  end

  task automatic access(input bit r, input bit w, input logic [AW-1:0] idx,
                        input logic [WB-1:0] be, input logic [DW-1:0] d, input bit c);
    rd_en = r; wr_en = w; index = idx; byte_en = be; data_in = d; clr_req = c;
    @(posedge clk); #1;
    rd_en = 0; wr_en = 0; clr_req = 0;
  endtask

  task automatic read_chk(input string nm, input logic [AW-1:0] idx, input logic [DW-1:0] expv);
    access(1, 0, idx, '0, '0, 0);
    chk({nm, "_valid"}, {31'd0, rd_valid}, 32'd1);
    chk(nm, {16'd0, data_out}, {16'd0, expv});
  endtask

  task automatic count_busy(input string nm, input bit poke_clr);
    int cnt = 0;
    while (busy && cnt < 200) begin
      clr_req = poke_clr && (cnt == 10);
      @(posedge clk); #1;
      cnt++;
    end
    clr_req = 0;
    chk(nm, cnt, DEPTH);
  endtask

  int sel;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", {16'd0, data_out}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk_on = 1;

    // Hold a read through the initial sweep; it is dropped until busy falls.
    rd_en = 1; index = '0; nrst = 1;
    count_busy("init_sweep_len", 0);
    @(posedge clk); #1;
    chk("first_rd_valid", {31'd0, rd_valid}, 32'd1);
    chk("first_rd_data", {16'd0, data_out}, 32'h0000);
    rd_en = 0;

    access(0, 1, 16'd10, 2'b11, 16'hA55A, 0);
    read_chk("rd10", 16'd10, 16'hA55A);
    read_chk("rd11", 16'd11, 16'h5A00);

    access(0, 1, 16'd20, 2'b11, 16'h1234, 0);
    access(0, 1, 16'd20, 2'b01, 16'hFFFF, 0);
    read_chk("rd20_be", 16'd20, 16'h12FF);

    access(1, 1, 16'd10, 2'b11, 16'hBEEF, 0);
    chk("rw_old_valid", {31'd0, rd_valid}, 32'd1);
    chk("rw_old_data", {16'd0, data_out}, 32'hA55A);
    read_chk("rw_new", 16'd10, 16'hBEEF);

    access(0, 1, 16'd62, 2'b11, 16'h1122, 0);
    read_chk("rd62", 16'd62, 16'h1122);
    access(1, 1, 16'd63, 2'b11, 16'hFFFF, 0);
    chk("err63_ae", {31'd0, addr_err}, 32'd1);
    chk("err63_rv", {31'd0, rd_valid}, 32'd0);
    chk("err63_hold", {16'd0, data_out}, 32'h1122);
    @(posedge clk); #1;
    chk("err_pulse", {31'd0, addr_err}, 32'd0);
    access(0, 1, 16'hFFFF, 2'b11, 16'hFFFF, 0);
    chk("errFFFF_ae", {31'd0, addr_err}, 32'd1);
    read_chk("rd62_kept", 16'd62, 16'h1122);
    read_chk("rd0_nowrap", 16'd0, 16'h0000);

    access(0, 1, 16'd4, 2'b11, 16'h1234, 0);
    read_chk("rd4", 16'd4, 16'h1234);
    access(0, 0, '0, '0, '0, 1);
    count_busy("clr_sweep_len", 1);
    read_chk("rd4_cleared", 16'd4, 16'h0000);

    access(0, 0, '0, '0, '0, 1);
    repeat (29) begin @(posedge clk); #1; end
    nrst = 0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd1);
    chk("midrst_dout", {16'd0, data_out}, 32'd0);
    @(posedge clk); #1;
    nrst = 1;
    count_busy("restart_sweep_len", 0);

    repeat (600) begin
      sel = $urandom_range(0, 9);
      rd_en   = ($urandom_range(0, 1) == 1);
      wr_en   = ($urandom_range(0, 2) == 0);
      byte_en = WB'($urandom);
      data_in = DW'($urandom);
      index   = (sel < 8) ? AW'($urandom_range(0, 70)) :
                (sel == 8) ? AW'(16'hFFFF - $urandom_range(0, 2)) : AW'($urandom_range(62, 63));
      clr_req = ($urandom_range(0, 149) == 0);
      @(posedge clk); #1;
    end
    rd_en = 0; wr_en = 0; clr_req = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/node_memory_bank.md
Name: node_memory_bank

Overview:
- Parametrised byte-addressed memory bank for per-node state storage.
- Word access is big-endian: the byte at index is the MSB byte; WORD_BYTES consecutive bytes form one word.
- Adds a registered read port with valid strobe, per-byte write enables, address range checking and a hardware clear sweep.
- Sits beside the node controller FSM, which reads and writes node table entries through it.

Parameters:
- BYTE_W, 8, bits per storage byte.
- WORD_BYTES, 2, bytes per access word (>=1).
- DEPTH, 64, number of bytes in the array (>=WORD_BYTES).
- ADDR_W, 16, width of the index port.

Ports:
- clk  in  1  clock; all state on rising edge.
- nrst  in  1  asynchronous active-low reset.
- wr_en  in  1  write request, sampled when busy=0.
- rd_en  in  1  read request, sampled when busy=0.
- index  in  ADDR_W  byte address of the word MSB byte.
- byte_en  in  WORD_BYTES  per-byte write enable; bit WORD_BYTES-1 maps to the byte at index.
- data_in  in  WORD_BYTES*BYTE_W  write word, MSB byte first.
- clr_req  in  1  one-cycle pulse; starts a full clear sweep.
- data_out  out  WORD_BYTES*BYTE_W  registered read word.
- rd_valid  out  1  one-cycle pulse; data_out valid.
- addr_err  out  1  one-cycle pulse; rejected out-of-range access.
- busy  out  1  clear sweep in progress; requests are ignored.

Behaviour:
- Clock is clk; reset is nrst, asynchronous and active-low.
- Reset (asserted): data_out=0, rd_valid=0, addr_err=0, busy=1, FSM=CLEAR, clear pointer=0. The array itself is not reset.
- FSM states:
  - CLEAR: writes 0 to byte[ptr] each cycle, ptr increments; busy=1.
  - After ptr=DEPTH-1 is written, the FSM moves to IDLE and busy drops the next cycle.
  - The sweep takes DEPTH cycles after nrst deasserts.
  - IDLE: busy=0, services requests. clr_req in IDLE moves the FSM to CLEAR with ptr=0. clr_req in CLEAR is ignored and does not restart the sweep.
- Range check: an access is legal iff index + WORD_BYTES <= DEPTH, computed at ADDR_W+1 bits so it cannot overflow. There is no wrap-around.
- Write (IDLE, wr_en=1, legal): on the clock edge, byte[index+k] <= data_in slice (WORD_BYTES-1-k) for each k with byte_en[WORD_BYTES-1-k]=1.
- Read (IDLE, rd_en=1, legal):
  - The cycle after the request, data_out = {byte[index], ..., byte[index+WORD_BYTES-1]} and rd_valid=1. Latency is 1.
  - data_out holds its value until the next valid read.
- Simultaneous legal rd_en and wr_en to overlapping bytes: the read returns pre-write (old) data, and the write still takes effect.
- Illegal access (wr_en or rd_en with index out of range, IDLE):
  - No array change.
  - addr_err=1 the next cycle, once per request cycle even if both rd_en and wr_en are set.
  - rd_valid=0 and data_out unchanged.
- Requests while busy=1 are dropped silently: no write, no rd_valid, no addr_err.
- clr_req together with wr_en/rd_en in IDLE: the access is serviced in that cycle and CLEAR starts on the next cycle. The written byte is later zeroed by the sweep.
- Reset mid-sweep or mid-access: outputs clear immediately and the sweep restarts from ptr=0 after deassertion.
- rd_valid and addr_err are never both 1.

Test Plan:
- Release nrst; hold rd_en=1, index=0 -> busy=1 for exactly 64 cycles, no rd_valid; then a read of index 0 gives data_out=0x0000 with rd_valid one cycle later.
- Write index=10, data_in=0xA55A, byte_en=2'b11; read index=10 -> data_out=0xA55A. Read index=11 -> 0x5A00.
- Write index=20 with 0x1234, then write 0xFFFF with byte_en=2'b01 -> read gives 0x12FF.
- Same cycle: rd_en and wr_en at index=10 with 0xBEEF over stored 0xA55A -> data_out=0xA55A; next read returns 0xBEEF.
- Access index=63 and index=0xFFFF -> addr_err pulses once each, rd_valid=0, byte[63] unchanged, no wrap into byte[0].
- clr_req after writing 0x1234 at index=4 -> busy=1 for 64 cycles, then read index=4 gives 0x0000. Assert nrst at sweep cycle 30 -> busy stays high and the sweep restarts with a full 64 cycles.
